// File: rtl/register_file_sb.sv
// register_file_sb: general-purpose register file with NUM_RD combinational
// read ports, one write port, optional write-to-read bypass, a per-register
// busy scoreboard for long-latency writes, and the program counter.
//
// Claim semantics: i_claim_en is a request and o_claim_ok is its combinational
// grant in the same cycle. A claim takes effect only when both are high at the
// posedge. A denied request leaves all state unchanged, and the requester must
// re-present it. The grant is independent of everything except the scoreboard
// and the write port.
module register_file_sb #(
   parameter int          XLEN        = 32,
   parameter int          NUM_REGS    = 32,
   parameter int          L2_NUM_REGS = 5,
   parameter int          NUM_RD      = 2,
   parameter bit          BYPASS      = 1'b1,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [NUM_RD*L2_NUM_REGS-1:0] i_rd_sel,
   output logic [NUM_RD*XLEN-1:0]        o_rd_data,
   output logic [NUM_RD-1:0]             o_rd_busy,
   input  logic                          i_wr_en,
   input  logic [L2_NUM_REGS-1:0]        i_wr_sel,
   input  logic [XLEN-1:0]               i_wr_data,
   input  logic                          i_claim_en,
   input  logic [L2_NUM_REGS-1:0]        i_claim_sel,
   output logic                          o_claim_ok,
   input  logic                          i_load_pc,
   input  logic [XLEN-1:0]               i_data_to_load_pc,
   input  logic                          i_inc_pc,
   output logic [XLEN-1:0]               o_program_counter,
   output logic [XLEN-1:0]               o_link_register,
   output logic [XLEN-1:0]               o_stack_pointer,
   output logic [NUM_REGS-1:0]           o_busy_mask
);

   // r0 has no storage; entries 1..NUM_REGS-1 are physical
   logic [XLEN-1:0]     regs [1:NUM_REGS-1];
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_nxt;
   logic [XLEN-1:0]     pc;
   logic                wr_hit;
   logic                claim_hit;

   assign wr_hit    = i_wr_en && (i_wr_sel != '0);
   assign claim_hit = o_claim_ok && (i_claim_sel != '0);

   // Claim grant: r0 is always free, a busy target is free if it is being written now
   always_comb begin
      o_claim_ok = i_claim_en &&
                   ((i_claim_sel == '0) || !busy[i_claim_sel] ||
                    (i_wr_en && (i_wr_sel == i_claim_sel)));
   end

   // Read ports: r0 reads 0, otherwise stored value, optionally forwarded from the write port
   always_comb begin
      o_rd_data = '0;
      o_rd_busy = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         logic [L2_NUM_REGS-1:0] sel;
         sel = i_rd_sel[k*L2_NUM_REGS +: L2_NUM_REGS];
         if (sel != '0) begin
            if (BYPASS && wr_hit && (i_wr_sel == sel)) begin
               o_rd_data[k*XLEN +: XLEN] = i_wr_data;
               o_rd_busy[k]              = 1'b0;
            end else begin
               o_rd_data[k*XLEN +: XLEN] = regs[sel];
               o_rd_busy[k]              = busy[sel];
            end
         end
      end
   end

   // Next scoreboard: a write retires its target, a granted claim (applied last) wins
   always_comb begin
      busy_nxt = busy;
      if (wr_hit)
         busy_nxt[i_wr_sel] = 1'b0;
      if (claim_hit)
         busy_nxt[i_claim_sel] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // Register storage and scoreboard; reset clears everything and drops same-cycle writes
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 1; i < NUM_REGS; i++)
            regs[i] <= '0;
         busy <= '0;
      end else begin
         if (wr_hit)
            regs[i_wr_sel] <= i_wr_data;
         busy <= busy_nxt;
      end
   end

   // Program counter: load has priority over increment; increment wraps
   always_ff @(posedge i_clk) begin
      if (i_rst)
         pc <= RESET_PC;
      else if (i_load_pc)
         pc <= i_data_to_load_pc;
      else if (i_inc_pc)
         pc <= pc + XLEN'(4);
   end

   assign o_program_counter = pc;
   assign o_link_register   = regs[1];
   assign o_stack_pointer   = regs[2];
   assign o_busy_mask       = busy;

endmodule
